serial_inequality_checker: RTL and testbench
============================================

# serial_inequality_checker

Bit-serial counterpart to the team's parallel 5-bit inequality comparator. It consumes two operands one bit pair per handshake, LSB first, and accumulates the per-bit XOR. After WIDTH bits it presents a registered verdict (differ/equal), the full mismatch mask, and the index of the lowest differing bit, held until downstream accepts it. It sits behind serial links where the two words arrive as bit streams instead of parallel buses.

## Interface
Parameters:
- WIDTH, 5, operand width in bits; must be at least 2.
- IDX_W, 3, width of bit-index fields; equals ceil(log2(WIDTH)).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  a bit pair is present on in_a/in_b.
- in_ready  out  1  the block can accept a bit pair.
- in_a  in  1  current bit of operand A.
- in_b  in  1  current bit of operand B.
- out_valid  out  1  verdict is available.
- out_ready  in  1  downstream accepts the verdict.
- result  out  1  1 if A != B, 0 if A == B.
- mismatch  out  WIDTH  per-bit A XOR B, with bit i from the i-th accepted pair.
- first_idx  out  IDX_W  lowest set bit of mismatch; 0 when result = 0.

## Operation
- Two states: COLLECT and HOLD. Reset state is COLLECT.
- COLLECT:
  - in_ready = 1 and out_valid = 0.
  - On in_valid & in_ready: write shadow_mask[cnt] <= in_a ^ in_b and increment cnt.
  - Cycles with in_valid = 0 change nothing.
- COLLECT -> HOLD on the handshake where cnt == WIDTH-1.
  - On that same edge, load mismatch (including the final bit), result = |mask, and first_idx = lowest set index.
  - cnt and shadow_mask clear to 0.
- HOLD:
  - in_ready = 0 and out_valid = 1.
  - in_valid, in_a and in_b are ignored.
  - result, mismatch and first_idx hold stable.
- HOLD -> COLLECT on out_valid & out_ready.
  - Output registers keep their values but are don't-care while out_valid = 0.
- cnt is IDX_W bits wide and counts 0..WIDTH-1. It never wraps past WIDTH-1 because the transition to HOLD clears it.
- in_ready is decoded combinationally from the state only. It never depends on in_valid or out_ready.
- Reset mid-word: partial cnt and shadow_mask are discarded. The next accepted pair is bit 0 of a new word.

## Timing
- Reset values: state = COLLECT, cnt = 0, shadow_mask = 0, out_valid = 0, result = 0, mismatch = 0, first_idx = 0. in_ready reads 1 once rst_n is high.
- Latency: out_valid rises on the edge that accepts bit WIDTH-1, so the verdict is visible in the following cycle.
- Minimum word period: WIDTH+1 cycles, i.e. WIDTH collect cycles plus at least one HOLD cycle.
- Bit accept and verdict release never coincide, because in_ready = 0 whenever out_valid = 1.
- Backpressure: out_ready low holds HOLD indefinitely, with all outputs unchanged cycle to cycle.
- out_ready high in the first HOLD cycle: in_ready returns to 1 on the next cycle.
- out_ready sampled high while in COLLECT has no effect.
- Asynchronous reset takes effect immediately, without waiting for an edge. Release is synchronous to the next clk edge.

## Structure
- Shared package contents:
  - state enum {COLLECT, HOLD}.
  - Default WIDTH = 5 and IDX_W = 3 constants.
  - A clog2-style helper for IDX_W.
- Sub-module lowest_set_index: combinational priority encoder.
  - Inputs: WIDTH-bit mask.
  - Outputs: IDX_W index plus an any-set flag.
  - Reused here for first_idx and result.
- Everything else is one FSM plus counter in the top module.

## Test plan
- Equal words: A = 10101, B = 10101 streamed LSB first, back-to-back -> out_valid in cycle 6, result = 0, mismatch = 00000, first_idx = 0.
- All bits differ: A = 11111 vs B = 00000 -> result = 1, mismatch = 11111, first_idx = 0.
- Single low bit: A = 11010 vs B = 11011 -> result = 1, mismatch = 00001, first_idx = 0. Single high bit: A = 10000 vs B = 00000 -> result = 1, mismatch = 10000, first_idx = 4.
- Gaps and backpressure:
  - Stimulus: in_valid toggles 1,0,1,0,... over a word; then hold out_ready = 0 for 3 HOLD cycles while driving in_valid = 1.
  - Required response: the verdict is unaffected by the gaps; outputs stay stable and in_ready = 0 throughout HOLD; only the 5 accepted pairs are counted.
- Reset mid-word:
  - Stimulus: accept 3 pairs that differ, assert rst_n = 0 for 1 cycle, then stream A = 00110 vs B = 00110.
  - Required response: result = 0 and mismatch = 00000, with no residue from the aborted word.
- Back-to-back words: out_ready tied high, two words (00000/00001 then 01000/01000) -> verdicts 1 (first_idx 0) then 0, with the second verdict visible 6 cycles after the first.

Source files
------------

// File: rtl/serial_inequality_checker_pkg.sv
// Shared types and constants for the bit-serial inequality checker.
// Default geometry matches the parallel 5-bit comparator it pairs with.
package serial_inequality_checker_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   // Smallest r with 2**r >= value; gives the width of a bit-index field.
   function automatic int clog2_ceil(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   localparam int DEFAULT_WIDTH = 5;
   localparam int DEFAULT_IDX_W = clog2_ceil(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_inequality_checker_lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit of a mask,
// plus a flag that any bit is set. Index reads 0 for an all-zero mask.
module lowest_set_index
   import serial_inequality_checker_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int IDX_W = DEFAULT_IDX_W
) (
   input  logic [WIDTH-1:0] mask,
   output logic [IDX_W-1:0] idx,
   output logic             any_set
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx = IDX_W'(i);
         end
      end
      any_set = |mask;
   end

endmodule

// File: rtl/serial_inequality_checker.sv
// Bit-serial A != B checker: collects WIDTH XOR bits LSB first, then holds a
// registered verdict (result, mismatch mask, lowest differing index) until accepted.
module serial_inequality_checker
   import serial_inequality_checker_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int IDX_W = DEFAULT_IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_a,
   input  logic             in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             result,
   output logic [WIDTH-1:0] mismatch,
   output logic [IDX_W-1:0] first_idx
);

   localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(WIDTH - 1);

   state_t           state_reg;
   state_t           state_next;
   logic [IDX_W-1:0] cnt_reg;
   logic [WIDTH-1:0] shadow_reg;
   logic [WIDTH-1:0] shadow_with_bit;
   logic             result_reg;
   logic [WIDTH-1:0] mismatch_reg;
   logic [IDX_W-1:0] first_idx_reg;
   logic             accept;
   logic             last_bit;
   logic [IDX_W-1:0] enc_idx;
   logic             enc_any;

   assign accept   = in_valid & in_ready;
   assign last_bit = (cnt_reg == LAST_CNT);

   // Shadow mask with the current pair's XOR merged in, so the final bit
   // reaches the encoder on the same edge the verdict is loaded.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_merge
         assign shadow_with_bit[gi] = (cnt_reg == IDX_W'(gi)) ? (in_a ^ in_b)
                                                             : shadow_reg[gi];
      end
   endgenerate

   lowest_set_index #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_lowest_set_index (
      .mask    (shadow_with_bit),
      .idx     (enc_idx),
      .any_set (enc_any)
   );

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         COLLECT: begin
            in_ready = 1'b1;
            if (in_valid && last_bit) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = COLLECT;
            end
         end
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= COLLECT;
         cnt_reg       <= '0;
         shadow_reg    <= '0;
         result_reg    <= 1'b0;
         mismatch_reg  <= '0;
         first_idx_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            if (last_bit) begin
               cnt_reg       <= '0;
               shadow_reg    <= '0;
               mismatch_reg  <= shadow_with_bit;
               result_reg    <= enc_any;
               first_idx_reg <= enc_idx;
            end else begin
               cnt_reg    <= cnt_reg + 1'b1;
               shadow_reg <= shadow_with_bit;
            end
         end
      end
   end

   assign result    = result_reg;
   assign mismatch  = mismatch_reg;
   assign first_idx = first_idx_reg;

endmodule

// File: tb/tb_serial_inequality_checker.sv
// Self-checking bench for serial_inequality_checker: directed words from the
// test plan plus randomized words with gaps and backpressure against a word-level model.
module tb_serial_inequality_checker;

   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         in_a = 1'b0;
   logic         in_b = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic         result;
   logic [W-1:0] mismatch;
   logic [2:0]   first_idx;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   serial_inequality_checker #(
      .WIDTH (W),
      .IDX_W (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .mismatch  (mismatch),
      .first_idx (first_idx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Word-level reference: verdict vector {out_valid, in_ready, result, mismatch, first_idx}
   // expected while a verdict for operands a/b is being held.
   function automatic logic [10:0] model_hold(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] m;
      logic [2:0]   idx;
      m   = a ^ b;
      idx = 3'd0;
      for (int i = 0; i < W; i++) begin
         if (m[i] && idx == 3'd0 && (m & ((5'd1 << i) - 5'd1)) == 5'd0) idx = 3'(i);
      end
      return {1'b1, 1'b0, (m != 5'd0), m, idx};
   endfunction

   function automatic logic [10:0] observed();
      return {out_valid, in_ready, result, mismatch, first_idx};
   endfunction

   // Streams one word LSB first; gaps[i] inserts one idle cycle before bit i.
   // Returns just after the edge that accepts the last bit.
   task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] gaps);
      for (int i = 0; i < W; i++) begin
         if (gaps[i]) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_a = 1'($urandom);
            in_b = 1'($urandom);
         end
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_a = a[i];
         in_b = b[i];
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic release_verdict();
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [10:0] obs;
      #2;
      obs = {out_valid, result, mismatch, first_idx, 3'b000};
      total++;
      if (obs !== 11'd0) begin
         bad++;
         $display("FAIL reset_outputs actual=%b required=%b", obs, 11'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if ({in_ready, out_valid} !== 2'b10) begin
         bad++;
         $display("FAIL reset_release in_ready/out_valid actual=%b required=10", {in_ready, out_valid});
      end
      $display("reset: in_ready=%0d out_valid=%0d", in_ready, out_valid);
   endtask

   task automatic test_equal();
      logic [W-1:0] a;
      logic [10:0]  exp;
      a = 5'b10101;
      for (int i = 0; i < W; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_a = a[i];
         in_b = a[i];
         @(negedge clk);
         total++;
         if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL equal_collect bit=%0d out_valid/in_ready actual=%b required=01", i, {out_valid, in_ready});
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      exp = model_hold(a, a);
      total++;
      if (observed() !== exp) begin
         bad++;
         $display("FAIL equal_verdict actual=%b required=%b", observed(), exp);
      end
      $display("word a=%b b=%b result=%0d mismatch=%b first_idx=%0d", a, a, result, mismatch, first_idx);
      release_verdict();
   endtask

   task automatic test_directed_words();
      logic [W-1:0] wa [3];
      logic [W-1:0] wb [3];
      logic [10:0]  exp;
      wa[0] = 5'b11111; wb[0] = 5'b00000;
      wa[1] = 5'b11010; wb[1] = 5'b11011;
      wa[2] = 5'b10000; wb[2] = 5'b00000;
      for (int w = 0; w < 3; w++) begin
         send_word(wa[w], wb[w], 5'b00000);
         @(negedge clk);
         exp = model_hold(wa[w], wb[w]);
         total++;
         if (observed() !== exp) begin
            bad++;
            $display("FAIL directed_word%0d actual=%b required=%b", w, observed(), exp);
         end
         $display("word a=%b b=%b result=%0d mismatch=%b first_idx=%0d", wa[w], wb[w], result, mismatch, first_idx);
         release_verdict();
      end
   endtask

   task automatic test_gaps_backpressure();
      logic [10:0] exp;
      send_word(5'b01101, 5'b00100, 5'b11111);
      in_valid = 1'b1;
      exp = model_hold(5'b01101, 5'b00100);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if (observed() !== exp) begin
            bad++;
            $display("FAIL gaps_hold cycle=%0d actual=%b required=%b", k, observed(), exp);
         end
         @(posedge clk); #1;
         in_a = 1'($urandom);
         in_b = 1'($urandom);
      end
      $display("word a=01101 b=00100 gaps+stall result=%0d mismatch=%b first_idx=%0d", result, mismatch, first_idx);
      release_verdict();
      send_word(5'b10011, 5'b10011, 5'b00000);
      @(negedge clk);
      exp = model_hold(5'b10011, 5'b10011);
      total++;
      if (observed() !== exp) begin
         bad++;
         $display("FAIL gaps_followup actual=%b required=%b", observed(), exp);
      end
      $display("word a=10011 b=10011 result=%0d mismatch=%b first_idx=%0d", result, mismatch, first_idx);
      release_verdict();
   endtask

   task automatic test_reset_midword();
      logic [10:0] exp;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_a = 1'b1;
         in_b = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if ({out_valid, result, mismatch, first_idx} !== 10'd0) begin
         bad++;
         $display("FAIL midword_async_reset actual=%b required=%b", {out_valid, result, mismatch, first_idx}, 10'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      send_word(5'b00110, 5'b00110, 5'b00000);
      @(negedge clk);
      exp = model_hold(5'b00110, 5'b00110);
      total++;
      if (observed() !== exp) begin
         bad++;
         $display("FAIL midword_next_word actual=%b required=%b", observed(), exp);
      end
      $display("word a=00110 b=00110 after reset result=%0d mismatch=%b first_idx=%0d", result, mismatch, first_idx);
      release_verdict();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] wa [2];
      logic [W-1:0] wb [2];
      logic         pa [10];
      logic         pb [10];
      int           vcyc [2];
      logic [8:0]   vval [2];
      logic [8:0]   exp;
      logic [10:0]  full;
      int           k;
      int           nv;
      logic         acc;
      wa[0] = 5'b00000; wb[0] = 5'b00001;
      wa[1] = 5'b01000; wb[1] = 5'b01000;
      for (int i = 0; i < 10; i++) begin
         pa[i] = wa[i / W][i % W];
         pb[i] = wb[i / W][i % W];
      end
      k = 0;
      nv = 0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_a = pa[0];
      in_b = pb[0];
      for (int c = 0; c < 40 && nv < 2; c++) begin
         @(negedge clk);
         if (out_valid) begin
            vcyc[nv] = cyc;
            vval[nv] = {result, mismatch, first_idx};
            nv++;
         end
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) k++;
         if (k < 10) begin
            in_valid = 1'b1;
            in_a = pa[k];
            in_b = pb[k];
         end else begin
            in_valid = 1'b0;
         end
      end
      out_ready = 1'b0;
      in_valid = 1'b0;
      total++;
      if (nv !== 2) begin
         bad++;
         $display("FAIL b2b_verdict_count actual=%0d required=2", nv);
      end else begin
         for (int w = 0; w < 2; w++) begin
            full = model_hold(wa[w], wb[w]);
            exp = full[8:0];
            total++;
            if (vval[w] !== exp) begin
               bad++;
               $display("FAIL b2b_verdict%0d actual=%b required=%b", w, vval[w], exp);
            end
            $display("word a=%b b=%b back-to-back verdict=%b at cycle %0d", wa[w], wb[w], vval[w], vcyc[w]);
         end
         total++;
         if (vcyc[1] - vcyc[0] !== 6) begin
            bad++;
            $display("FAIL b2b_spacing actual=%0d required=6", vcyc[1] - vcyc[0]);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [10:0]  exp;
      int           stall;
      for (int n = 0; n < 24; n++) begin
         a = 5'($urandom);
         b = ($urandom_range(0, 2) == 0) ? a : 5'($urandom);
         send_word(a, b, 5'($urandom));
         exp = model_hold(a, b);
         stall = $urandom_range(0, 3);
         for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            total++;
            if (observed() !== exp) begin
               bad++;
               $display("FAIL random_word%0d hold=%0d actual=%b required=%b", n, s, observed(), exp);
            end
            @(posedge clk); #1;
            in_valid = 1'($urandom);
            in_a = 1'($urandom);
            in_b = 1'($urandom);
         end
         $display("word a=%b b=%b stall=%0d result=%0d mismatch=%b first_idx=%0d", a, b, stall, result, mismatch, first_idx);
         release_verdict();
      end
   endtask

   initial begin
      test_reset();
      test_equal();
      test_directed_words();
      test_gaps_backpressure();
      test_reset_midword();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
